// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver with a parallel valid/ready output.
//
// The serial line goes through a 2-flop synchronizer. An internal prescaler
// divides clk into oversample ticks, and each bit is sampled at its centre.
// The frame format is set by parameters: 5..9 data bits (LSB first), optional
// odd or even parity, and 1 or 2 stop bits. A received word is held on
// data_out until data_ready accepts it. A frame that completes while a word
// is still held is dropped, and overrun is set.
//
// Parameters:
//   CLK_DIV    system clocks per oversample tick (>=1)
//   OS         oversample ticks per bit (even, >=4)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_in       serial line, idle high, asynchronous to clk
//   data_out    received word, LSB = first bit on the line
//   data_valid  data_out and the flags hold a word not yet accepted
//   data_ready  consumer accepts the held word when high with data_valid
//   parity_err  held word failed its parity check
//   frame_err   held word had at least one stop bit sampled low
//   overrun     a frame was dropped while the current word was held
module uart_rx_os #(
  parameter int CLK_DIV   = 4,
  parameter int OS        = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2(OS);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [OW-1:0] HALF_LAST  = OW'(OS / 2 - 1);
  localparam logic [OW-1:0] BIT_LAST   = OW'(OS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  localparam logic          PAR_ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic rx_meta, rx_s, rx_prev;
  logic fall;

  logic [PW-1:0] presc;
  logic [OW-1:0] os_cnt;
  logic          tick;
  logic          sample_pt;

  logic                 clr_cnt;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 commit;

  logic [IW-1:0]        bit_idx;
  logic                 par_acc;
  logic                 stop_idx;
  logic                 frame_acc;
  logic [DATA_BITS-1:0] data_sh;

  logic                 frame_bad;
  logic                 par_bad;
  logic                 accept;

  // Input synchronizer. rx_prev holds the previous synchronized value, so a
  // start edge needs the line to have been seen high first. A line held low
  // after a framing error therefore cannot re-trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Bit timing. The counters restart on the start edge, so every sample
  // point lands mid-bit relative to the synchronized falling edge. The start
  // bit is checked after half a bit, and every later bit a full bit after it.
  assign tick      = (presc == PRESC_LAST);
  assign sample_pt = tick && (os_cnt == ((state == S_START) ? HALF_LAST : BIT_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      os_cnt <= '0;
    end else if (clr_cnt) begin
      presc  <= '0;
      os_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        os_cnt <= sample_pt ? '0 : os_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clr_cnt    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_next = S_START;
          clr_cnt    = 1'b1;
        end
      end
      S_START: begin
        // A high line at mid start bit is a glitch. Drop it silently.
        if (sample_pt) begin
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample_pt) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample_pt) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at the centre of the last stop bit. This gives half a bit
        // of slack before the next start edge.
        if (sample_pt) begin
          stop_en = 1'b1;
          if (stop_idx == STOP_LAST) begin
            commit     = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-frame bookkeeping. Everything here restarts on the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= '0;
      par_acc   <= 1'b0;
      stop_idx  <= 1'b0;
      frame_acc <= 1'b0;
    end else if (clr_cnt) begin
      bit_idx   <= '0;
      par_acc   <= 1'b0;
      stop_idx  <= 1'b0;
      frame_acc <= 1'b0;
    end else begin
      if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en || par_en) begin
        par_acc <= par_acc ^ rx_s;
      end
      if (stop_en) begin
        stop_idx  <= 1'b1;
        frame_acc <= frame_acc | ~rx_s;
      end
    end
  end

  // Right-shifting register: after DATA_BITS shifts the first bit on the
  // line sits in the LSB.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      data_sh <= {rx_s, data_sh[DATA_BITS-1:1]};
    end
  end

  // The last stop bit is sampled in the commit cycle itself, so it is folded
  // in here rather than taken from frame_acc.
  assign frame_bad = frame_acc | ~rx_s;
  assign par_bad   = (PARITY != 0) && (par_acc != PAR_ODD);
  assign accept    = data_valid & data_ready;

  // Output holding register. A word accepted in the commit cycle frees the
  // slot for the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      if (!data_valid || data_ready) begin
        data_out   <= data_sh;
        parity_err <= par_bad;
        frame_err  <= frame_bad;
        data_valid <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      data_valid <= 1'b0;
    end
  end

endmodule
